// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett reduction stream.
//   state_t : control FSM states (IDLE = unconfigured, RUN, DRAIN)
//   cfg_t   : modulus configuration {q, mu, b}, sized for the largest LOGQ
//   LAT     : input-accept to output-valid latency in cycles, no stall
package barrett_pkg;

  localparam int MAX_LOGQ    = 64;
  localparam int MAX_LOGLOGQ = $clog2(MAX_LOGQ + 1);
  localparam int LAT         = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [MAX_LOGQ-1:0]    q;
    logic [MAX_LOGQ:0]      mu;
    logic [MAX_LOGLOGQ-1:0] b;
  } cfg_t;

  // A configuration is usable only with 2 <= b <= logq and a non-zero modulus.
  function automatic logic cfg_legal(input logic [MAX_LOGQ-1:0]    q,
                                     input logic [MAX_LOGLOGQ-1:0] b,
                                     input int                     logq);
    return (b >= MAX_LOGLOGQ'(2)) && (32'(b) <= 32'(logq)) && (q != '0);
  endfunction

endpackage

// File: rtl/barrett_core.sv
// Barrett datapath for stages S2..S4, no control logic.
//   enable : advance S2/S3 registers
//   c      : operand from the S1 register (K bits)
//   q/mu/b : active modulus, floor(4^b/q) and bit length of q
//   r      : reduced result from S4 (combinational from S3 registers)
module barrett_core #(
  parameter  int LOGQ    = 64,
  localparam int K       = 2 * LOGQ,
  localparam int LOGLOGQ = $clog2(LOGQ + 1),
  localparam int PW      = K + LOGQ + 1,
  localparam int RW      = LOGQ + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [K-1:0]       c,
  input  logic [LOGQ-1:0]    q,
  input  logic [LOGQ:0]      mu,
  input  logic [LOGLOGQ-1:0] b,
  output logic [LOGQ-1:0]    r
);

  logic [K-1:0]  c_shift;
  logic [PW-1:0] prod2;
  logic [RW-1:0] c2, c3, tq3;
  logic [RW-1:0] q_ext, r0, r1, r2;

  assign c_shift = c >> (b - LOGLOGQ'(1));

  // r = C - t*q is below 3q for C < q^2, so only the low RW bits of C and
  // t*q are needed; the difference is exact modulo 2^RW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod2 <= '0;
      c2    <= '0;
      c3    <= '0;
      tq3   <= '0;
    end else if (enable) begin
      prod2 <= PW'(c_shift) * PW'(mu);
      c2    <= c[RW-1:0];
      c3    <= c2;
      // shift by b then by 1 so b+1 never overflows the b width
      tq3   <= RW'((prod2 >> b) >> 1) * q_ext;
    end
  end

  always_comb begin
    q_ext = RW'(q);
    r0    = c3 - tq3;
    r1    = (r0 >= q_ext) ? r0 - q_ext : r0;
    r2    = (r1 >= q_ext) ? r1 - q_ext : r1;
    r     = LOGQ'(r2);
  end

endmodule

// File: rtl/barrett_stream.sv
// Streaming Barrett modular reducer: out_t = in_c mod q, 4-cycle elastic
// pipeline with valid/ready handshakes and an opaque tag per operand.
//   cfg_we/cfg_q/cfg_mu/cfg_b : configuration write (q, floor(4^k/q), k)
//   cfg_err  : one-cycle pulse on a rejected write
//   cfg_busy : a configuration is waiting for the pipeline to drain
//   in_*     : operand stream (C, tag); out_* : result stream (C mod q, tag)
module barrett_stream
  import barrett_pkg::*;
#(
  parameter  int LOGQ    = 64,
  parameter  int TAGW    = 8,
  localparam int K       = 2 * LOGQ,
  localparam int LOGLOGQ = $clog2(LOGQ + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [LOGQ-1:0]    cfg_q,
  input  logic [LOGQ:0]      cfg_mu,
  input  logic [LOGLOGQ-1:0] cfg_b,
  output logic               cfg_err,
  output logic               cfg_busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K-1:0]       in_c,
  input  logic [TAGW-1:0]    in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOGQ-1:0]    out_t,
  output logic [TAGW-1:0]    out_tag
);

  state_t          state;
  cfg_t            active, pending, wr_cfg;
  logic            enable, accept, wr_ok, occupied, drained;
  logic            v1, v2, v3;
  logic [K-1:0]    c1;
  logic [TAGW-1:0] tag1, tag2, tag3;
  logic [LOGQ-1:0] core_r;

  assign enable   = !out_valid || out_ready;
  assign in_ready = (state == RUN) && enable;
  assign accept   = in_valid && in_ready;
  assign cfg_busy = (state == DRAIN);
  assign drained  = !(v1 || v2 || v3 || out_valid);
  // An operand accepted in the same cycle as a write still counts as in
  // flight, so it completes under the configuration it was accepted with.
  assign occupied = !drained || accept;
  assign wr_ok    = cfg_we && cfg_legal(MAX_LOGQ'(cfg_q), MAX_LOGLOGQ'(cfg_b), LOGQ);

  always_comb begin
    wr_cfg    = '0;
    wr_cfg.q  = MAX_LOGQ'(cfg_q);
    wr_cfg.mu = (MAX_LOGQ + 1)'(cfg_mu);
    wr_cfg.b  = MAX_LOGLOGQ'(cfg_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      active  <= '0;
      pending <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !wr_ok;
      case (state)
        IDLE: begin
          if (wr_ok) begin
            active <= wr_cfg;
            state  <= RUN;
          end
        end
        RUN: begin
          if (wr_ok) begin
            if (occupied) begin
              pending <= wr_cfg;
              state   <= DRAIN;
            end else begin
              active <= wr_cfg;
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            active <= wr_ok ? wr_cfg : pending;
            state  <= RUN;
          end else if (wr_ok) begin
            pending <= wr_cfg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      c1        <= '0;
      tag1      <= '0;
      tag2      <= '0;
      tag3      <= '0;
      out_t     <= '0;
      out_tag   <= '0;
    end else if (enable) begin
      v1 <= accept;
      if (accept) begin
        c1   <= in_c;
        tag1 <= in_tag;
      end
      v2        <= v1;
      tag2      <= tag1;
      v3        <= v2;
      tag3      <= tag2;
      out_valid <= v3;
      out_t     <= core_r;
      out_tag   <= tag3;
    end
  end

  barrett_core #(
    .LOGQ(LOGQ)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .c      (c1),
    .q      (LOGQ'(active.q)),
    .mu     ((LOGQ + 1)'(active.mu)),
    .b      (LOGLOGQ'(active.b)),
    .r      (core_r)
  );

endmodule

// File: doc/barrett_stream.md
BARRETT_STREAM -- requirements
Module: barrett_stream

Interface
REQ-001 SHALL have parameter LOGQ, default 64, maximum modulus bit length.
REQ-002 SHALL have parameter TAGW, default 8, width of the opaque tag carried with each operand.
REQ-003 SHALL derive localparams K = 2*LOGQ, LOGLOGQ = clog2(LOGQ+1) and LAT = 4 (input-accept to output-valid cycles, no stall).
REQ-004 SHALL have ports clk, in, 1, the single clock: all logic on its rising edge.
REQ-005 SHALL have port rst, in, 1, reset: asynchronous, active-high.
REQ-006 SHALL have ports cfg_we, in, 1, config write strobe; cfg_q, in, LOGQ, modulus q; cfg_mu, in, LOGQ+1, mu = floor(4^k/q); cfg_b, in, LOGLOGQ, k = bit length of q.
REQ-007 SHALL have ports cfg_err, out, 1, one-cycle pulse when a write is rejected; cfg_busy, out, 1, a config write is pending drain.
REQ-008 SHALL have ports in_valid, in, 1; in_ready, out, 1; in_c, in, K, operand C; in_tag, in, TAGW.
REQ-009 SHALL have ports out_valid, out, 1; out_ready, in, 1; out_t, out, LOGQ, C mod q; out_tag, out, TAGW.

Function
REQ-010 SHALL compute t = ((C >> (k-1)) * mu) >> (k+1), then r = C - t*q, then subtract q from r at most twice while r >= q.
REQ-011 SHALL use full-width intermediates (no truncation) for r of at least LOGQ+2 bits; out_t = r[LOGQ-1:0].
REQ-012 SHALL leave out_t unspecified for C >= q*q; out_valid, out_tag and ordering SHALL remain correct in that case.
REQ-013 SHALL be a 4-stage elastic pipeline: S1 input register, S2 shift and mu multiply, S3 t*q multiply, S4 subtract/correct feeding the output register.
REQ-014 SHALL advance all stages together on enable = !out_valid || out_ready; on !enable every stage holds.
REQ-015 SHALL accept a transfer exactly when in_valid && in_ready, and deliver exactly when out_valid && out_ready.
REQ-016 SHALL keep results strictly in input order, each with its own tag.
REQ-017 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-018 SHALL hold out_t and out_tag stable while out_valid && !out_ready.
REQ-019 SHALL implement an FSM with states IDLE (unconfigured), RUN and DRAIN.
REQ-020 in IDLE: in_ready=0; a valid cfg_we loads the active config and moves to RUN next cycle.
REQ-021 in RUN: in_ready = enable; a valid cfg_we with any stage or the output occupied latches a pending config and moves to DRAIN; with the pipeline empty it applies immediately and stays in RUN.
REQ-022 in DRAIN: in_ready=0 and cfg_busy=1; once all stage valids and out_valid are 0, SHALL apply the pending config and return to RUN the next cycle.
REQ-023 a valid cfg_we in DRAIN SHALL overwrite the pending config (last write wins).
REQ-024 SHALL reject a write with cfg_b < 2, cfg_b > LOGQ or cfg_q == 0: pulse cfg_err and change no state.
REQ-025 operands in flight SHALL always complete with the config active when they were accepted.

Reset
REQ-026 on rst: FSM=IDLE; all stage valids, out_valid, in_ready, cfg_busy and cfg_err = 0; out_t, out_tag and config registers = 0.
REQ-027 rst mid-operation SHALL discard in-flight operands and any pending config; no output follows reset release until a new configuration is written.

Structure
REQ-028 barrett_pkg SHALL hold the FSM state enum, the LAT constant and a config struct {q, mu, b}.
REQ-029 SHALL place the datapath of S2-S4 in one sub-module barrett_core, driven by an enable and free of control logic.

Verification
REQ-030 Config q=17, k=5, mu=60; stream C=288, 17, 0 -> out_t=16, 0, 0, first out_valid 4 cycles after accept, tags preserved.
REQ-031 Back-to-back 6 operands with out_ready low for 10 cycles -> in_ready drops, no loss or duplication, order kept, output held stable.
REQ-032 3 operands in flight at q=17, then write q=13, k=4, mu=19, then C=168 -> the first three reduce mod 17, cfg_busy high during drain, then out_t=12.
REQ-033 cfg_b=1 or cfg_q=0 -> one-cycle cfg_err, config and FSM unchanged.
REQ-034 Assert rst with 3 operands in flight -> out_valid=0 immediately, FSM=IDLE, in_ready=0, no stale output after reconfiguration.
REQ-035 LOGQ=64, random 64-bit primes, 10^4 random C < q^2 with random backpressure -> all match the golden model.
